// File: rtl/writeback_unit.sv
// writeback_unit
//
// Final pipeline stage. Merges single-cycle ALU results with backpressured
// long-latency results (load / mul-div) into at most one register-file write
// per cycle. It also tracks which registers still wait on a long-latency
// result and stalls decode on RAW/WAW hazards against them.
//
// Ports:
//   clk, rst_n                          clock, synchronous active-low reset
//   issue_valid/long/rd/rs1/rs2         instruction presented by decode
//   issue_stall                         decode must hold; instruction not issued
//   alu_valid/rd/data                   ALU result, no backpressure
//   mem_valid/ready/rd/data             long-path result handshake
//   rf_we/rf_waddr/rf_wdata             registered register-file write port
//   pending                             bit i set = reg i awaits a long result
//
// Handshake (long path): a result transfers on a rising edge where
// mem_valid & mem_ready are both high. While mem_ready is low the producer
// holds mem_rd/mem_data stable and the block ignores them. mem_ready depends
// only on rst_n and the FIFO occupancy, never on mem_valid.
module writeback_unit #(
    parameter  int XLEN     = 32,
    parameter  int NREGS    = 32,
    parameter  int LQ_DEPTH = 2,
    localparam int AW       = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            issue_valid,
    input  logic            issue_long,
    input  logic [AW-1:0]   issue_rd,
    input  logic [AW-1:0]   issue_rs1,
    input  logic [AW-1:0]   issue_rs2,
    output logic            issue_stall,
    input  logic            alu_valid,
    input  logic [AW-1:0]   alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            mem_valid,
    output logic            mem_ready,
    input  logic [AW-1:0]   mem_rd,
    input  logic [XLEN-1:0] mem_data,
    output logic            rf_we,
    output logic [AW-1:0]   rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic [NREGS-1:0] pending
);

    localparam int PW = $clog2(LQ_DEPTH);
    localparam int CW = PW + 1;

    // Long-path result FIFO
    logic [AW-1:0]   lq_rd   [LQ_DEPTH];
    logic [XLEN-1:0] lq_data [LQ_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;

    logic fifo_full;
    logic fifo_empty;
    logic push;
    logic pop;

    // Set when the write currently on rf_* came from the FIFO; only those
    // writes retire a pending bit.
    logic rf_from_fifo;
    logic sb_set;
    logic [NREGS-1:0] pending_next;

    assign fifo_full  = (count == CW'(LQ_DEPTH));
    assign fifo_empty = (count == '0);
    assign mem_ready  = rst_n & ~fifo_full;
    assign push       = mem_valid & mem_ready;
    // ALU has priority; the FIFO head only drains on ALU-idle cycles.
    assign pop        = ~alu_valid & ~fifo_empty;

    // Stall is forced low during reset so nothing looks blocked while the
    // scoreboard is being cleared.
    assign issue_stall = rst_n & issue_valid &
                         (pending[issue_rs1] | pending[issue_rs2] | pending[issue_rd]);

    assign sb_set = issue_valid & ~issue_stall & issue_long & (issue_rd != '0);

    // Clear first, then set, so a same-edge collision leaves the bit set.
    always_comb begin
        pending_next = pending;
        if (rf_we && rf_from_fifo) begin
            pending_next[rf_waddr] = 1'b0;
        end
        if (sb_set) begin
            pending_next[issue_rd] = 1'b1;
        end
    end

    // FIFO storage carries no reset; occupancy is governed by count.
    always_ff @(posedge clk) begin
        if (push) begin
            lq_rd[wr_ptr]   <= mem_rd;
            lq_data[wr_ptr] <= mem_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            rf_we        <= 1'b0;
            rf_waddr     <= '0;
            rf_wdata     <= '0;
            rf_from_fifo <= 1'b0;
            pending      <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end

            // Writes to x0 are suppressed but still consume their source.
            if (alu_valid) begin
                rf_we        <= (alu_rd != '0);
                rf_waddr     <= alu_rd;
                rf_wdata     <= alu_data;
                rf_from_fifo <= 1'b0;
            end else if (!fifo_empty) begin
                rf_we        <= (lq_rd[rd_ptr] != '0);
                rf_waddr     <= lq_rd[rd_ptr];
                rf_wdata     <= lq_data[rd_ptr];
                rf_from_fifo <= 1'b1;
            end else begin
                rf_we        <= 1'b0;
                rf_from_fifo <= 1'b0;
            end

            pending <= pending_next;
        end
    end

endmodule

// File: tb/tb_writeback_unit.sv
// tb_writeback_unit
//
// Bench for writeback_unit: directed scenarios with literal expectations,
// then a randomized phase. A behavioural model (queue of pending results,
// bit array of waiting registers, next expected write) is compared against
// the DUT on every falling edge once reset has been applied.
module tb_writeback_unit;

    localparam int XLEN     = 32;
    localparam int NREGS    = 32;
    localparam int AW       = 5;
    localparam int LQ_DEPTH = 2;

    // Clock / reset
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic             issue_valid, issue_long, issue_stall;
    logic [AW-1:0]    issue_rd, issue_rs1, issue_rs2;
    logic             alu_valid;
    logic [AW-1:0]    alu_rd;
    logic [XLEN-1:0]  alu_data;
    logic             mem_valid, mem_ready;
    logic [AW-1:0]    mem_rd;
    logic [XLEN-1:0]  mem_data;
    logic             rf_we;
    logic [AW-1:0]    rf_waddr;
    logic [XLEN-1:0]  rf_wdata;
    logic [NREGS-1:0] pending;

    writeback_unit dut (
        .clk(clk), .rst_n(rst_n),
        .issue_valid(issue_valid), .issue_long(issue_long),
        .issue_rd(issue_rd), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_stall(issue_stall),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_rd(mem_rd), .mem_data(mem_data),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .pending(pending)
    );

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;
    bit mem_acc = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard / behavioural model
    logic [AW+XLEN-1:0] exp_q[$];   // results accepted but not yet written
    logic [NREGS-1:0]   m_pend;
    bit                 m_we;
    logic [AW-1:0]      m_waddr;
    logic [XLEN-1:0]    m_wdata;
    bit                 m_from_q;

    function automatic bit m_ready();
        return (rst_n === 1'b1) && (exp_q.size() < LQ_DEPTH);
    endfunction

    function automatic bit m_stall();
        return (rst_n === 1'b1) && (issue_valid === 1'b1) &&
               (m_pend[issue_rs1] || m_pend[issue_rs2] || m_pend[issue_rd]);
    endfunction

    task automatic model_step();
        bit rdy, stl;
        logic [AW+XLEN-1:0] e;
        if (rst_n !== 1'b1) begin
            exp_q.delete();
            m_pend = '0; m_we = 0; m_waddr = '0; m_wdata = '0; m_from_q = 0;
        end else begin
            rdy = m_ready();
            stl = m_stall();
            if (m_we && m_from_q) m_pend[m_waddr] = 1'b0;
            if (issue_valid && !stl && issue_long && issue_rd != 0) m_pend[issue_rd] = 1'b1;
            if (alu_valid) begin
                m_we = (alu_rd != 0); m_waddr = alu_rd; m_wdata = alu_data; m_from_q = 0;
            end else if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                m_waddr = e[AW+XLEN-1:XLEN]; m_wdata = e[XLEN-1:0];
                m_we = (m_waddr != 0); m_from_q = 1;
            end else begin
                m_we = 0; m_from_q = 0;
            end
            if (mem_valid && rdy) exp_q.push_back({mem_rd, mem_data});
        end
    endtask

    initial begin
        m_pend = '0; m_we = 0; m_waddr = '0; m_wdata = '0; m_from_q = 0;
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Compare process
    initial forever begin
        @(negedge clk);
        mem_acc = mem_valid && m_ready();
        if (chk_en) begin
            chk("mem_ready", mem_ready, m_ready());
            chk("issue_stall", issue_stall, m_stall());
            chk("pending", pending, m_pend);
            chk("rf_we", rf_we, m_we);
            if (m_we) begin
                chk("rf_waddr", rf_waddr, m_waddr);
                chk("rf_wdata", rf_wdata, m_wdata);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        issue_valid = 0; issue_long = 0; issue_rd = '0; issue_rs1 = '0; issue_rs2 = '0;
        alu_valid = 0; alu_rd = '0; alu_data = '0;
        mem_valid = 0; mem_rd = '0; mem_data = '0;
    endtask

    task automatic random_cycle();
        rst_n = ($urandom_range(0, 299) != 0);
        alu_valid = ($urandom_range(0, 2) == 0);
        alu_rd    = AW'($urandom_range(0, 31));
        alu_data  = $urandom;
        issue_valid = $urandom_range(0, 1);
        issue_long  = $urandom_range(0, 1);
        issue_rd    = AW'($urandom_range(0, 7));
        issue_rs1   = AW'($urandom_range(0, 7));
        issue_rs2   = AW'($urandom_range(0, 15));
        // Producer holds an offered result until it is accepted.
        if (!mem_valid || mem_acc) begin
            mem_valid = $urandom_range(0, 1);
            mem_rd    = AW'($urandom_range(0, 9));
            mem_data  = $urandom;
        end
    endtask

    initial begin
        rst_n = 0;
        idle_inputs();
        step(); step();
        chk("reset_rf_we", rf_we, 0);
        chk("reset_waddr", rf_waddr, 0);
        chk("reset_wdata", rf_wdata, 0);
        chk("reset_pending", pending, 0);
        chk("reset_mem_ready", mem_ready, 0);
        rst_n = 1;
        #1;
        chk("ready_after_reset", mem_ready, 1);
        chk_en = 1;

        // ALU only: one-cycle write pulse
        alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
        step();
        alu_valid = 0;
        chk("alu_we", rf_we, 1);
        chk("alu_waddr", rf_waddr, 5);
        chk("alu_wdata", rf_wdata, 32'hDEADBEEF);
        step();
        chk("alu_pulse_end", rf_we, 0);

        // Long path with scoreboard
        issue_valid = 1; issue_long = 1; issue_rd = 7;
        step();
        chk("long_set_pending", pending, 32'h80);
        issue_long = 0; issue_rd = 3; issue_rs1 = 7;
        #1;
        chk("raw_stall", issue_stall, 1);
        mem_valid = 1; mem_rd = 7; mem_data = 32'h1234;
        step();
        mem_valid = 0;
        chk("mem_n1_no_we", rf_we, 0);
        chk("mem_n1_stall", issue_stall, 1);
        step();
        chk("mem_n2_we", rf_we, 1);
        chk("mem_n2_waddr", rf_waddr, 7);
        chk("mem_n2_wdata", rf_wdata, 32'h1234);
        chk("mem_n2_pending", pending, 32'h80);
        step();
        chk("mem_n3_cleared", pending, 0);
        chk("mem_n3_no_stall", issue_stall, 0);
        issue_valid = 0; issue_rd = 0; issue_rs1 = 0;

        // Priority / backpressure
        alu_valid = 1; alu_rd = 1; alu_data = 32'hA1A10001;
        mem_valid = 1; mem_rd = 10; mem_data = 32'h100;
        step();
        mem_rd = 11; mem_data = 32'h200;
        step();
        chk("bp_full", mem_ready, 0);
        chk("bp_alu_waddr", rf_waddr, 1);
        mem_rd = 12; mem_data = 32'h300;
        step();
        chk("bp_held", mem_ready, 0);
        chk("bp_alu_prio", rf_waddr, 1);
        alu_valid = 0;
        step();
        chk("bp_first_waddr", rf_waddr, 10);
        chk("bp_first_wdata", rf_wdata, 32'h100);
        chk("bp_ready_after_pop", mem_ready, 1);
        step();
        mem_valid = 0;
        chk("bp_second_waddr", rf_waddr, 11);
        chk("bp_second_wdata", rf_wdata, 32'h200);
        step();
        chk("bp_third_waddr", rf_waddr, 12);
        chk("bp_third_wdata", rf_wdata, 32'h300);
        step();
        chk("bp_drained", rf_we, 0);

        // x0 handling
        alu_valid = 1; alu_rd = 0; alu_data = 32'hFFFF;
        step();
        alu_valid = 0;
        chk("x0_alu_no_we", rf_we, 0);
        mem_valid = 1; mem_rd = 0; mem_data = 32'h55;
        step();
        mem_valid = 0;
        step();
        chk("x0_mem_no_we", rf_we, 0);
        step();
        alu_valid = 1; alu_rd = 2; alu_data = 32'h2;
        mem_valid = 1; mem_rd = 13; mem_data = 32'h1313;
        step();
        chk("x0_popped_one_entry", mem_ready, 1);
        mem_rd = 14; mem_data = 32'h1414;
        step();
        alu_valid = 0; mem_valid = 0;
        step();
        chk("x0_drain_a", rf_waddr, 13);
        step();
        chk("x0_drain_b", rf_waddr, 14);
        issue_valid = 1; issue_long = 1; issue_rd = 0;
        step();
        issue_valid = 0; issue_long = 0;
        chk("x0_no_pending", pending, 0);

        // WAW stall
        issue_valid = 1; issue_long = 1; issue_rd = 9;
        step();
        issue_long = 0;
        #1;
        chk("waw_pending", pending, 32'h200);
        chk("waw_stall_a", issue_stall, 1);
        step();
        chk("waw_stall_b", issue_stall, 1);
        mem_valid = 1; mem_rd = 9; mem_data = 32'h99;
        step();
        mem_valid = 0;
        chk("waw_stall_c", issue_stall, 1);
        step();
        chk("waw_write", rf_waddr, 9);
        chk("waw_stall_d", issue_stall, 1);
        step();
        chk("waw_released", issue_stall, 0);
        issue_valid = 0; issue_rd = 0;

        // Reset mid-flight
        issue_valid = 1; issue_long = 1; issue_rd = 7;
        step();
        issue_valid = 0; issue_long = 0; issue_rd = 0;
        alu_valid = 1; alu_rd = 2; alu_data = 32'h22;
        mem_valid = 1; mem_rd = 7; mem_data = 32'h777;
        step();
        mem_valid = 0;
        chk("mid_pending", pending, 32'h80);
        rst_n = 0;
        #1;
        chk("mid_rst_ready_low", mem_ready, 0);
        step();
        chk("mid_rst_we", rf_we, 0);
        chk("mid_rst_pending", pending, 0);
        chk("mid_rst_ready_held", mem_ready, 0);
        rst_n = 1; alu_valid = 0;
        #1;
        chk("mid_ready_back", mem_ready, 1);
        step();
        chk("mid_no_stale_a", rf_we, 0);
        step();
        chk("mid_no_stale_b", rf_we, 0);

        // Randomized phase
        for (int i = 0; i < 3000; i++) begin
            random_cycle();
            step();
        end
        rst_n = 1;
        idle_inputs();
        repeat (4) step();
        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
